uio_bus_sched: RTL and testbench

Round-robin scheduler that shares the 8-bit bidirectional `uio` pad bus between up to `N_REQ` internal requesters inside `tt_um_supreme_meme`. It grants the bus to one requester at a time and inserts a mandatory all-inputs turnaround cycle between owners. It enforces a maximum hold time when other requesters are waiting. It drives `uio_out`/`uio_oe` at the top level and returns `uio_in` to the owner.

---
 rtl/uio_bus_sched_pkg.sv | 43 ++++
 rtl/uio_bus_sched_if.sv | 28 ++
 rtl/uio_bus_sched_arb.sv | 37 +++
 rtl/uio_bus_sched.sv | 119 +++++++++++
 tb/tb_uio_bus_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uio_bus_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_pkg: shared types and round-robin pick helper for uio_bus_sched.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uio_pkg;

  localparam int UIO_W    = 8;
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } uio_state_t;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set, non-excluded request found walking upward from start, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] start,
                                       input logic [RR_MAX-1:0]   exclude,
                                       input int                  n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      j = int'(start) + k;
      if (j >= n) j = j - n;
      if (k < n && !res.valid && req[j[RR_IDX_W-1:0]] && !exclude[j[RR_IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = j[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uio_bus_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_bus_sched_if: requester-side and pad-side signals of the uio bus.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uio_bus_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]                req;
  logic [uio_pkg::UIO_W*N_REQ-1:0] req_out;
  logic [uio_pkg::UIO_W*N_REQ-1:0] req_oe;
  logic [N_REQ-1:0]                grant;
  logic [uio_pkg::UIO_W-1:0]       rd_data;
  logic [uio_pkg::UIO_W-1:0]       uio_in;
  logic [uio_pkg::UIO_W-1:0]       uio_out;
  logic [uio_pkg::UIO_W-1:0]       uio_oe;

  modport master (
    input  req, req_out, req_oe, uio_in,
    output grant, rd_data, uio_out, uio_oe
  );

  modport slave (
    output req, req_out, req_oe, uio_in,
    input  grant, rd_data, uio_out, uio_oe
  );
endinterface
`default_nettype wire

// File: rtl/uio_bus_sched_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin picker with an exclusion mask.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import uio_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic [N_REQ-1:0] exclude_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [RR_MAX-1:0] w_req_ext;
  logic [RR_MAX-1:0] w_excl_ext;
  rr_pick_t          w_pick;
  logic              w_unused_idx;

  always_comb begin
    w_req_ext                = '0;
    w_excl_ext               = '0;
    w_req_ext[N_REQ-1:0]     = req_i;
    w_excl_ext[N_REQ-1:0]    = exclude_i;
  end

  assign w_pick       = rr_pick(w_req_ext, RR_IDX_W'(start_i), w_excl_ext, N_REQ);
  assign idx_o        = w_pick.idx[IDX_W-1:0];
  assign valid_o      = w_pick.valid;
  assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/uio_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_bus_sched: round-robin owner of the uio pads with turnaround cycle.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uio_bus_sched
  import uio_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_i,
  output logic                  busy_o,
  uio_bus_sched_if.master       bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  uio_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q,  last_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [UIO_W-1:0]  rd_data_q;

  logic [N_REQ-1:0]  w_owner_oh;
  logic [IDX_W-1:0]  w_base;
  logic [IDX_W-1:0]  w_start;
  logic [N_REQ-1:0]  w_excl;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;

  assign w_owner_oh = N_REQ'(1) << owner_q;

  // One arbiter serves both cases: IDLE searches after last, OWN after owner.
  assign w_base  = (state_q == OWN) ? owner_q : last_q;
  assign w_start = (w_base == IDX_W'(N_REQ - 1)) ? '0 : w_base + IDX_W'(1);
  assign w_excl  = (state_q == OWN) ? w_owner_oh : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (bus.req),
    .start_i   (w_start),
    .exclude_i (w_excl),
    .idx_o     (w_pick_idx),
    .valid_o   (w_pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_data_q <= bus.uio_in;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena_i && w_pick_valid) begin
          state_d = TURN;
          owner_d = w_pick_idx;
        end
      end
      TURN: begin
        state_d = OWN;
        cnt_d   = '0;
      end
      OWN: begin
        if (!bus.req[owner_q] || !ena_i) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1) && w_pick_valid) begin
          state_d = TURN;
          owner_d = w_pick_idx;
          last_d  = owner_q;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pads are driven only from OWN; async reset forces IDLE and floats them at once.
  always_comb begin
    bus.grant   = '0;
    bus.uio_out = '0;
    bus.uio_oe  = '0;
    if (state_q == OWN) begin
      bus.grant   = w_owner_oh;
      bus.uio_out = bus.req_out[UIO_W*int'(owner_q) +: UIO_W];
      bus.uio_oe  = bus.req_oe[UIO_W*int'(owner_q) +: UIO_W];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uio_bus_sched: directed and random stimulus against a grant model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uio_bus_sched;

  localparam int N  = 4;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          busy;
  logic [N-1:0]  req;
  logic [8*N-1:0] r_out;
  logic [8*N-1:0] r_oe;
  logic [7:0]    pad_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: who holds the bus, who is queued behind a turnaround, grant cycles used.
  int         m_owner;
  int         m_next;
  int         m_last;
  int         m_held;
  logic [7:0] m_rd;

  uio_bus_sched_if #(.N_REQ(N)) bus ();

  assign bus.req     = req;
  assign bus.req_out = r_out;
  assign bus.req_oe  = r_oe;
  assign bus.uio_in  = pad_in;

  uio_bus_sched #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena_i  (ena),
    .busy_o (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_next  = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_rd    = 8'h00;
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      model_reset();
    end else begin
      m_rd = pad_in;
      if (m_next >= 0) begin
        m_owner = m_next;
        m_next  = -1;
        m_held  = 1;
      end else if (m_owner >= 0) begin
        w = pick(req, (m_owner + 1) % N, m_owner);
        if (!req[m_owner] || !ena) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_held == MH && w >= 0) begin
          m_next  = w;
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_held == MH + 1) begin
          m_held = 1;
        end else begin
          m_held++;
        end
      end else if (ena && req != '0) begin
        m_next = pick(req, (m_last + 1) % N, -1);
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    logic [7:0]   eo;
    logic [7:0]   ee;
    eg = '0;
    eo = 8'h00;
    ee = 8'h00;
    if (m_owner >= 0) begin
      eg = 4'b0001 << m_owner;
      eo = r_out[8*m_owner +: 8];
      ee = r_oe[8*m_owner +: 8];
    end
    chk("grant",   32'(bus.grant),   32'(eg));
    chk("uio_out", 32'(bus.uio_out), 32'(eo));
    chk("uio_oe",  32'(bus.uio_oe),  32'(ee));
    chk("busy",    32'(busy),        32'(m_owner >= 0 || m_next >= 0));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    req    = 4'b1111;
    r_out  = 32'h4433_2211;
    r_oe   = 32'hFF00_F0FF;
    pad_in = 8'h5A;
    model_reset();
    #1;
    chk("reset_oe",    32'(bus.uio_oe), 32'h0);
    chk("reset_grant", 32'(bus.grant),  32'h0);
    cycles(2);

    // Release reset with everyone requesting: TURN then requester 0.
    rst = 1'b0;
    cycle();
    chk("first_turn_busy",  32'(busy),      32'h1);
    chk("first_turn_grant", 32'(bus.grant), 32'h0);
    cycle();
    chk("first_grant", 32'(bus.grant), 32'h1);

    // Full contention: rotation through all four owners and back to 0.
    for (int i = 0; i < 4 * (MH + 1) + 2; i++) begin
      pad_in = 8'($urandom);
      cycle();
    end

    req = 4'b0000;
    cycles(3);

    // Single requester 2 with known pad values, then release.
    req   = 4'b0100;
    r_out = 32'h00A5_0000 | 32'h1100_0033;
    r_oe  = 32'h000F_0000 | 32'hF000_000F;
    cycles(2);
    chk("req2_out", 32'(bus.uio_out), 32'hA5);
    chk("req2_oe",  32'(bus.uio_oe),  32'h0F);
    cycles(3);
    req = 4'b0000;
    cycle();
    chk("req2_release_oe",    32'(bus.uio_oe), 32'h0);
    chk("req2_release_grant", 32'(bus.grant),  32'h0);

    // Lone requester 1 keeps the bus across counter wrap with no gaps.
    req = 4'b0010;
    cycles(2);
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk("lone_req1", 32'(bus.grant), 32'h2);
    end

    // Asynchronous reset between edges while requester 1 owns the bus.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_oe",    32'(bus.uio_oe), 32'h0);
    chk("async_rst_grant", 32'(bus.grant),  32'h0);
    model_reset();
    cycles(2);
    rst = 1'b0;
    req = 4'b1111;
    cycles(2);
    chk("post_rst_grant", 32'(bus.grant), 32'h1);

    // Hand the bus to requester 3, then drop ena.
    req = 4'b1000;
    cycles(4);
    chk("owner3", 32'(bus.grant), 32'h8);
    ena = 1'b0;
    cycle();
    chk("ena_off_grant", 32'(bus.grant), 32'h0);
    chk("ena_off_busy",  32'(busy),      32'h0);
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("ena_off_hold", 32'(bus.grant), 32'h0);
    end
    ena = 1'b1;
    cycles(2);
    chk("ena_on_rr", 32'(bus.grant), 32'h1);

    // Random traffic with persistent requests and occasional ena drops.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      ena    = ($urandom_range(31) != 0);
      r_out  = $urandom;
      r_oe   = $urandom;
      pad_in = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
